// File: rtl/frac_rate_pkg.sv
// Shared constants, types and helpers for the fractional-rate pulse decoder.
// Optional feature macro: PCOUNT_EN (adds the per-period pulse count output).
package frac_rate_pkg;

  localparam int N_DEF = 16;
  localparam int IDX_W = $clog2(N_DEF + 1);

  typedef logic [N_DEF:0] coef_t;

  // Number of times coefficient bit k is selected per period of 2^n phases.
  function automatic int unsigned weight(input int n, input int k);
    if (k >= n) return 1;
    return 32'd1 << (n - 1 - k);
  endfunction

endpackage

// File: rtl/frac_rate_if.sv
// Pulse-stream input and recovered-word output bundle of the decoder.
// Optional feature macro: PCOUNT_EN (adds PCOUNT).
//
// Handshake: C_VALID high means C_OUT (and PCOUNT) hold an unconsumed word;
// the word transfers on any rising edge where C_VALID and C_READY are both
// high. While C_VALID=1 and C_READY=0 the word is held stable.
interface frac_rate_if import frac_rate_pkg::*; #(parameter int N = N_DEF);
  logic       EN;
  logic       SYNC;
  logic       Z;
  logic       C_READY;
  logic [N:0] C_OUT;
  logic       C_VALID;
  logic       LOCKED;
  logic       ERR;
  logic       OVR;
`ifdef PCOUNT_EN
  logic [N:0] PCOUNT;

  modport master (output EN, SYNC, Z, C_READY,
                  input C_OUT, C_VALID, LOCKED, ERR, OVR, PCOUNT);
  modport slave (input EN, SYNC, Z, C_READY,
                 output C_OUT, C_VALID, LOCKED, ERR, OVR, PCOUNT);
`else
  modport master (output EN, SYNC, Z, C_READY,
                  input C_OUT, C_VALID, LOCKED, ERR, OVR);
  modport slave (input EN, SYNC, Z, C_READY,
                 output C_OUT, C_VALID, LOCKED, ERR, OVR);
`endif
endinterface

// File: rtl/frac_phase_ctr.sv
// Replica phase counter of the binary rate multiplier. Produces the selected
// coefficient index (trailing ones of the phase), whether this is the first
// selection of that index in the period, the end-of-period flag and a flag
// for SYNC arriving at a nonzero phase.
module frac_phase_ctr import frac_rate_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int IDX_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  output logic [IDX_W-1:0] k,
  output logic             first_sel,
  output logic             last_phase,
  output logic             resync
);

  logic [N-1:0] phase;
  logic [N-1:0] v;

  // Effective phase of this cycle: SYNC forces the period start.
  always_comb v = sync ? '0 : phase;

  // Phase advances once per enabled cycle, wrapping mod 2^N.
  always_ff @(posedge clk) begin
    if (rst)     phase <= '0;
    else if (en) phase <= v + 1'b1;
  end

  // Index = count of trailing ones; all-ones phase selects index N.
  always_comb begin
    k = IDX_W'(N);
    for (int i = N - 1; i >= 0; i--)
      if (!v[i]) k = IDX_W'(i);
  end

  // First selection of k happens at v = 2^k - 1, i.e. no bits above k are set.
  always_comb begin
    first_sel  = ((v >> k) == '0);
    last_phase = &v;
    resync     = en & sync & (phase != '0);
  end

endmodule

// File: rtl/frac_rate_decoder.sv
// Receive end of the fractional-rate pulse interface: recovers the N+1 bit
// coefficient word from the pulse stream Z, one word per 2^N enabled cycles.
// Optional feature macro: PCOUNT_EN (per-period count of Z=1 samples).
module frac_rate_decoder import frac_rate_pkg::*; #(
  parameter int N = N_DEF
) (
  input logic        CK,
  input logic        RST,
  frac_rate_if.slave bus
);

  localparam int IDX_W = $clog2(N + 1);

  logic [IDX_W-1:0] k;
  logic             first_sel;
  logic             last_phase;
  logic             resync;
  logic             act;
  logic             mismatch;
  logic             complete;
  logic             load;
  logic [N:0]       partial;
  logic [N:0]       next_word;
  logic [N:0]       c_out_q;
  logic             c_valid_q;
  logic             locked_q;
  logic             err_q;
  logic             ovr_q;

  frac_phase_ctr #(.N(N), .IDX_W(IDX_W)) u_phase (
    .clk       (CK),
    .rst       (RST),
    .en        (bus.EN),
    .sync      (bus.SYNC),
    .k         (k),
    .first_sel (first_sel),
    .last_phase(last_phase),
    .resync    (resync)
  );

  // Decode qualifiers; the locking SYNC cycle itself is already a sample.
  always_comb begin
    act       = bus.EN & (locked_q | bus.SYNC);
    next_word = partial;
    if (first_sel) next_word[k] = bus.Z;
    mismatch  = act & ~first_sel & (bus.Z != partial[k]);
    complete  = act & last_phase;
    load      = complete & (~c_valid_q | bus.C_READY);
  end

  // Sample bank: first selection writes, later selections only compare.
  always_ff @(posedge CK) begin
    if (RST)      partial <= '0;
    else if (act) partial <= next_word;
  end

  // Output word register, handshake and sticky status flags.
  always_ff @(posedge CK) begin
    if (RST) begin
      c_out_q   <= '0;
      c_valid_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (bus.EN & bus.SYNC) locked_q <= 1'b1;
      if ((bus.Z & ~bus.EN) | (resync & locked_q) | mismatch) err_q <= 1'b1;
      if (load) begin
        c_out_q   <= next_word;
        c_valid_q <= 1'b1;
      end else if (complete) begin
        ovr_q <= 1'b1;
      end else if (c_valid_q & bus.C_READY) begin
        c_valid_q <= 1'b0;
      end
    end
  end

  assign bus.C_OUT   = c_out_q;
  assign bus.C_VALID = c_valid_q;
  assign bus.LOCKED  = locked_q;
  assign bus.ERR     = err_q;
  assign bus.OVR     = ovr_q;

`ifdef PCOUNT_EN
  logic [N:0] pacc;
  logic [N:0] pcount_next;
  logic [N:0] pcount_q;

  // Running pulse count; every SYNC starts a fresh period at phase 0.
  always_comb pcount_next = ((bus.EN & bus.SYNC) ? '0 : pacc) + (N+1)'(bus.Z);

  // Accumulator and its output copy, loaded alongside C_OUT.
  always_ff @(posedge CK) begin
    if (RST) begin
      pacc     <= '0;
      pcount_q <= '0;
    end else begin
      if (act)  pacc     <= complete ? '0 : pcount_next;
      if (load) pcount_q <= pcount_next;
    end
  end

  assign bus.PCOUNT = pcount_q;
`endif

endmodule
